// File: rtl/mult_share_arbiter.sv
// Round-robin sharing of one fixed-latency pipelined multiplier among N_REQ requesters.
// In-flight tags ride a delay line aligned with the multiplier output; each requester owns one response slot.
module mult_share_arbiter #(
  parameter int N_REQ        = 4,
  parameter int MULT_LATENCY = 3,
  parameter int TAG_W        = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [64*N_REQ-1:0]    req_x,
  input  logic [64*N_REQ-1:0]    req_y,
  output logic [N_REQ-1:0]       rsp_valid,
  input  logic [N_REQ-1:0]       rsp_ready,
  output logic [128*N_REQ-1:0]   rsp_product,
  output logic [63:0]            mult_x,
  output logic [63:0]            mult_y,
  input  logic [127:0]           mult_product,
  output logic                   busy
);

  logic [TAG_W-1:0]  rr_ptr;
  logic [TAG_W-1:0]  win_idx;
  logic              win_found;
  logic [N_REQ-1:0]  inflight;
  logic [N_REQ-1:0]  eligible;
  logic [MULT_LATENCY:0] dl_valid;
  logic [TAG_W-1:0]  dl_tag [MULT_LATENCY+1];
  logic              cap_valid;
  logic [TAG_W-1:0]  cap_tag;

  // Slot frees only on the edge after a handshake, so rsp_ready never reaches the grant path.
  assign eligible  = req_valid & ~inflight & ~rsp_valid;
  assign cap_valid = dl_valid[MULT_LATENCY];
  assign cap_tag   = dl_tag[MULT_LATENCY];
  assign busy      = (|inflight) | (|rsp_valid);

  always_comb begin
    int idx;
    idx       = 0;
    win_found = 1'b0;
    win_idx   = '0;
    req_ready = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % N_REQ;
      if (!win_found && eligible[idx]) begin
        win_found = 1'b1;
        win_idx   = TAG_W'(idx);
      end
    end
    if (win_found) req_ready[win_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr   <= '0;
      mult_x   <= '0;
      mult_y   <= '0;
      dl_valid <= '0;
      for (int s = 0; s <= MULT_LATENCY; s++) dl_tag[s] <= '0;
    end else begin
      dl_valid  <= {dl_valid[MULT_LATENCY-1:0], win_found};
      dl_tag[0] <= win_idx;
      for (int s = 1; s <= MULT_LATENCY; s++) dl_tag[s] <= dl_tag[s-1];
      if (win_found) begin
        mult_x <= req_x[int'(win_idx)*64 +: 64];
        mult_y <= req_y[int'(win_idx)*64 +: 64];
        rr_ptr <= (win_idx == TAG_W'(N_REQ-1)) ? '0 : win_idx + TAG_W'(1);
      end else begin
        mult_x <= '0;
        mult_y <= '0;
      end
    end
  end

  // Capture, handshake and accept may hit different slots on the same edge; capture and
  // accept never share a slot because an occupied slot is not eligible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight    <= '0;
      rsp_valid   <= '0;
      rsp_product <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (cap_valid && cap_tag == TAG_W'(i)) begin
          rsp_valid[i]             <= 1'b1;
          rsp_product[i*128 +: 128] <= mult_product;
          inflight[i]              <= 1'b0;
        end else begin
          if (rsp_valid[i] && rsp_ready[i]) rsp_valid[i] <= 1'b0;
          if (win_found && win_idx == TAG_W'(i)) inflight[i] <= 1'b1;
        end
      end
    end
  end

  a_no_overwrite: assert property (@(posedge clk) disable iff (!rst_n)
    cap_valid |-> !rsp_valid[cap_tag]);

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter with an ideal 3-stage multiplier model.
module tb_mult_share_arbiter;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [64*N-1:0] req_x = '0;
  logic [64*N-1:0] req_y = '0;
  logic [N-1:0]   rsp_valid;
  logic [N-1:0]   rsp_ready = '0;
  logic [128*N-1:0] rsp_product;
  logic [63:0]    mult_x, mult_y;
  logic [127:0]   mult_product;
  logic           busy;
  logic [127:0]   p1 = '0, p2 = '0, p3 = '0;

  int n_cmp = 0;
  int n_err = 0;

  mult_share_arbiter #(.N_REQ(N), .MULT_LATENCY(3), .TAG_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_product(rsp_product),
    .mult_x(mult_x), .mult_y(mult_y), .mult_product(mult_product),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Ideal multiplier: product visible three edges after operands are registered; never reset.
  always @(posedge clk) begin
    p1 <= {64'b0, mult_x} * {64'b0, mult_y};
    p2 <= p1;
    p3 <= p2;
  end
  assign mult_product = p3;

  task tick;
    @(posedge clk);
    #1;
  endtask

  task do_reset;
    rst_n = 1'b0;
    req_valid = '0;
    rsp_ready = '0;
    req_x = '0;
    req_y = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task test_reset;
    #1 rst_n = 1'b0;
    #2;
    n_cmp++; if (rsp_valid !== 4'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %b expected 0000", rsp_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (mult_x !== 64'd0 || mult_y !== 64'd0) begin n_err++; $display("FAIL reset_mult_xy: got %h %h expected 0 0", mult_x, mult_y); end
    n_cmp++; if (rsp_product !== '0) begin n_err++; $display("FAIL reset_rsp_product: got %h expected 0", rsp_product); end
    n_cmp++; if (req_ready !== 4'b0) begin n_err++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task test_single(input int idx, input logic [63:0] x, input logic [63:0] y, input logic [127:0] exp_p);
    logic [3:0] oh;
    oh = 4'b0001 << idx;
    req_valid = '0;
    req_valid[idx] = 1'b1;
    req_x[idx*64 +: 64] = x;
    req_y[idx*64 +: 64] = y;
    #1;
    n_cmp++; if (req_ready !== oh) begin n_err++; $display("FAIL single_ready: got %b expected %b", req_ready, oh); end
    tick;
    req_valid = '0;
    n_cmp++; if (mult_x !== x || mult_y !== y) begin n_err++; $display("FAIL single_operands: got %h %h expected %h %h", mult_x, mult_y, x, y); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy: got %b expected 1", busy); end
    for (int k = 1; k <= 3; k++) begin
      tick;
      n_cmp++; if (rsp_valid !== 4'b0) begin n_err++; $display("FAIL single_early_rsp: cycle %0d got %b expected 0000", k, rsp_valid); end
    end
    tick;
    n_cmp++; if (rsp_valid !== oh) begin n_err++; $display("FAIL single_rsp_valid: got %b expected %b", rsp_valid, oh); end
    n_cmp++; if (rsp_product[idx*128 +: 128] !== exp_p) begin n_err++; $display("FAIL single_product: got %h expected %h", rsp_product[idx*128 +: 128], exp_p); end
    rsp_ready = oh;
    tick;
    rsp_ready = '0;
    n_cmp++; if (rsp_valid !== 4'b0 || busy !== 1'b0) begin n_err++; $display("FAIL single_handshake: got valid %b busy %b expected 0000 0", rsp_valid, busy); end
    n_cmp++; if (rsp_product[idx*128 +: 128] !== exp_p) begin n_err++; $display("FAIL single_product_hold: got %h expected %h", rsp_product[idx*128 +: 128], exp_p); end
  endtask

  task test_fairness;
    int expg, ngr, nrsp, w;
    int gcnt [N];
    logic [127:0] expp [N];
    logic [3:0] oh;
    do_reset;
    for (int i = 0; i < N; i++) begin
      gcnt[i] = 0;
      expp[i] = '0;
      req_x[i*64 +: 64] = 64'(1000*i + 3);
      req_y[i*64 +: 64] = 64'hFFFF_0000_0000_0000 + 64'(i);
    end
    rsp_ready = '1;
    req_valid = '1;
    expg = 0; ngr = 0; nrsp = 0;
    for (int c = 0; c < 30; c++) begin
      #1;
      for (int i = 0; i < N; i++) begin
        if (rsp_valid[i]) begin
          nrsp++;
          n_cmp++; if (rsp_product[i*128 +: 128] !== expp[i]) begin n_err++; $display("FAIL fair_product: req %0d got %h expected %h", i, rsp_product[i*128 +: 128], expp[i]); end
        end
      end
      w = -1;
      for (int i = 0; i < N; i++) if (req_ready[i]) w = i;
      if (w >= 0) begin
        oh = 4'b0001 << expg;
        n_cmp++; if (req_ready !== oh) begin n_err++; $display("FAIL fair_order: got %b expected %b", req_ready, oh); end
        expp[w] = {64'b0, req_x[w*64 +: 64]} * {64'b0, req_y[w*64 +: 64]};
        gcnt[w]++;
        ngr++;
        expg = (expg + 1) % N;
      end
      tick;
      if (w >= 0) begin
        req_x[w*64 +: 64] = req_x[w*64 +: 64] + 64'd17;
        if (gcnt[w] == 4) req_valid[w] = 1'b0;
      end
    end
    n_cmp++; if (ngr !== 16) begin n_err++; $display("FAIL fair_grants: got %0d expected 16", ngr); end
    n_cmp++; if (nrsp !== 16) begin n_err++; $display("FAIL fair_responses: got %0d expected 16", nrsp); end
  endtask

  task test_backpressure;
    int w;
    int gcnt [N];
    logic [127:0] expp [N];
    logic seen1;
    do_reset;
    for (int i = 0; i < N; i++) begin
      gcnt[i] = 0;
      expp[i] = '0;
      req_x[i*64 +: 64] = 64'h0123_4567_0000_0000 + 64'(i*5 + 1);
      req_y[i*64 +: 64] = 64'(i*3 + 7);
    end
    rsp_ready = 4'b1101;
    req_valid = '1;
    seen1 = 1'b0;
    for (int c = 0; c < 28; c++) begin
      #1;
      for (int i = 0; i < N; i++) begin
        if (rsp_valid[i]) begin
          if (i == 1) seen1 = 1'b1;
          n_cmp++; if (rsp_product[i*128 +: 128] !== expp[i]) begin n_err++; $display("FAIL bp_product: req %0d got %h expected %h", i, rsp_product[i*128 +: 128], expp[i]); end
        end
      end
      if (seen1) begin
        n_cmp++; if (rsp_valid[1] !== 1'b1) begin n_err++; $display("FAIL bp_hold_valid: cycle %0d got %b expected 1", c, rsp_valid[1]); end
      end
      if (c > 1) begin
        n_cmp++; if (req_ready[1] !== 1'b0) begin n_err++; $display("FAIL bp_ready1: cycle %0d got %b expected 0", c, req_ready[1]); end
      end
      w = -1;
      for (int i = 0; i < N; i++) if (req_ready[i]) w = i;
      if (w >= 0) begin
        expp[w] = {64'b0, req_x[w*64 +: 64]} * {64'b0, req_y[w*64 +: 64]};
        if (c < 24) gcnt[w]++;
      end
      tick;
      if (w >= 0) req_x[w*64 +: 64] = req_x[w*64 +: 64] + 64'd17;
    end
    n_cmp++; if (!seen1) begin n_err++; $display("FAIL bp_seen1: got 0 expected 1"); end
    n_cmp++; if (gcnt[0] !== 4 || gcnt[1] !== 1 || gcnt[2] !== 4 || gcnt[3] !== 4)
      begin n_err++; $display("FAIL bp_grant_counts: got %0d %0d %0d %0d expected 4 1 4 4", gcnt[0], gcnt[1], gcnt[2], gcnt[3]); end
    req_valid = '0;
    rsp_ready[1] = 1'b1;
    tick;
    n_cmp++; if (rsp_valid[1] !== 1'b0) begin n_err++; $display("FAIL bp_release: got %b expected 0", rsp_valid[1]); end
  endtask

  task test_same_cycle;
    do_reset;
    req_valid = 4'b0001;
    req_x[0 +: 64] = 64'd6;
    req_y[0 +: 64] = 64'd7;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL sc_accept0: got %b expected 0001", req_ready); end
    tick;
    req_valid = 4'b0100;
    req_x[128 +: 64] = 64'h1234;
    req_y[128 +: 64] = 64'h10;
    #1;
    n_cmp++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL sc_accept2: got %b expected 0100", req_ready); end
    tick;
    req_valid = '0;
    repeat (3) tick;
    n_cmp++; if (rsp_valid !== 4'b0001) begin n_err++; $display("FAIL sc_pre: got %b expected 0001", rsp_valid); end
    rsp_ready = 4'b0001;
    req_valid = 4'b1001;
    req_x[192 +: 64] = 64'hABCD;
    req_y[192 +: 64] = 64'd2;
    #1;
    n_cmp++; if (req_ready !== 4'b1000) begin n_err++; $display("FAIL sc_accept3: got %b expected 1000", req_ready); end
    tick;
    rsp_ready = '0;
    n_cmp++; if (rsp_valid !== 4'b0100) begin n_err++; $display("FAIL sc_capture_handshake: got %b expected 0100", rsp_valid); end
    n_cmp++; if (rsp_product[256 +: 128] !== 128'h12340) begin n_err++; $display("FAIL sc_product2: got %h expected 12340", rsp_product[256 +: 128]); end
    n_cmp++; if (rsp_product[0 +: 128] !== 128'd42) begin n_err++; $display("FAIL sc_product0_hold: got %h expected 2a", rsp_product[0 +: 128]); end
    n_cmp++; if (mult_x !== 64'hABCD) begin n_err++; $display("FAIL sc_mult_x: got %h expected abcd", mult_x); end
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL sc_req0_next: got %b expected 0001", req_ready); end
    req_valid = '0;
  endtask

  task test_reset_midflight;
    do_reset;
    req_valid = 4'b1000;
    req_x[192 +: 64] = 64'd9;
    req_y[192 +: 64] = 64'd11;
    #1;
    tick;
    req_valid = '0;
    repeat (4) tick;
    n_cmp++; if (rsp_valid !== 4'b1000 || rsp_product[384 +: 128] !== 128'd99)
      begin n_err++; $display("FAIL mf_setup: got %b %h expected 1000 63", rsp_valid, rsp_product[384 +: 128]); end
    req_valid = 4'b0111;
    req_x[0 +: 64] = 64'd5;  req_y[0 +: 64] = 64'd5;
    req_x[64 +: 64] = 64'd6; req_y[64 +: 64] = 64'd6;
    req_x[128 +: 64] = 64'd7; req_y[128 +: 64] = 64'd7;
    #1;
    repeat (3) tick;
    n_cmp++; if (busy !== 1'b1 || mult_x !== 64'd7) begin n_err++; $display("FAIL mf_pre: got busy %b x %h expected 1 7", busy, mult_x); end
    rst_n = 1'b0;
    req_valid = '0;
    #1;
    n_cmp++; if (rsp_valid !== 4'b0 || busy !== 1'b0) begin n_err++; $display("FAIL mf_async_valid: got %b %b expected 0000 0", rsp_valid, busy); end
    n_cmp++; if (mult_x !== 64'd0 || mult_y !== 64'd0) begin n_err++; $display("FAIL mf_async_mult: got %h %h expected 0 0", mult_x, mult_y); end
    n_cmp++; if (rsp_product !== '0) begin n_err++; $display("FAIL mf_async_product: got %h expected 0", rsp_product); end
    n_cmp++; if (req_ready !== 4'b0) begin n_err++; $display("FAIL mf_async_ready: got %b expected 0000", req_ready); end
    repeat (2) tick;
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick;
      n_cmp++; if (rsp_valid !== 4'b0 || busy !== 1'b0) begin n_err++; $display("FAIL mf_stale: cycle %0d got %b %b expected 0000 0", k, rsp_valid, busy); end
    end
  endtask

  initial begin
    test_reset;
    test_single(0, 64'd3, 64'd5, 128'd15);
    test_single(2, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
    test_fairness;
    test_backpressure;
    test_same_cycle;
    test_reset_midflight;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
